// File: rtl/countdown_timer.sv
// Six-digit BCD countdown timer (MM:SS.hh): digit-pair loading, 10 ms decrement,
// stop at zero with a blinking alarm. Every output is a register.
module countdown_timer #(
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        load,
  input  logic [1:0]  sel,
  input  logic [7:0]  sw_digits,
  output logic [23:0] digits,
  output logic        running,
  output logic        expired,
  output logic        alarm
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  localparam logic [7:0] BlinkLast = 8'(BLINK_TICKS - 1);

  state_e      state;
  logic [7:0]  blink_cnt;
  logic [23:0] load_val;
  logic [23:0] dec_val;
  logic        ss_eff;
  logic        at_zero;
  logic        dec_zero;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Subtract one hundredth; digit 3 (seconds tens) wraps to 5, all others to 9.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    logic [23:0] r;
    logic [3:0]  d;
    logic        borrow;
    borrow = 1'b1;
    r      = v;
    for (int i = 0; i < 6; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = (i == 3) ? 4'd5 : 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  always_comb begin
    load_val = digits;
    unique case (sel)
      2'b00: load_val = '0;
      2'b01: load_val = {digits[23:8], clamp(sw_digits[7:4], 4'd9),
                         clamp(sw_digits[3:0], 4'd9)};
      2'b10: load_val = {digits[23:16], clamp(sw_digits[7:4], 4'd5),
                         clamp(sw_digits[3:0], 4'd9), digits[7:0]};
      2'b11: load_val = {clamp(sw_digits[7:4], 4'd5), clamp(sw_digits[3:0], 4'd9),
                         digits[15:0]};
      default: load_val = digits;
    endcase
  end

  // A coincident load always swallows start_stop, even where the load itself is ignored.
  assign ss_eff   = start_stop & ~load;
  assign dec_val  = bcd_dec(digits);
  assign at_zero  = (digits == 24'd0);
  assign dec_zero = (dec_val == 24'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      digits    <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (load) begin
            digits <= load_val;
          end else if (start_stop && !at_zero) begin
            state   <= StRun;
            running <= 1'b1;
          end
        end
        StPause: begin
          if (load) begin
            digits <= load_val;
          end else if (start_stop) begin
            state   <= StRun;
            running <= 1'b1;
          end
        end
        StRun: begin
          if (ss_eff) begin
            state   <= StPause;
            running <= 1'b0;
          end else if (tick) begin
            // A zero count (loaded while paused) expires without wrapping.
            if (at_zero || dec_zero) begin
              state     <= StDone;
              digits    <= '0;
              running   <= 1'b0;
              expired   <= 1'b1;
              alarm     <= 1'b1;
              blink_cnt <= '0;
            end else begin
              digits <= dec_val;
            end
          end
        end
        StDone: begin
          if (ss_eff) begin
            state     <= StIdle;
            expired   <= 1'b0;
            alarm     <= 1'b0;
            blink_cnt <= '0;
          end else if (tick) begin
            if (blink_cnt == BlinkLast) begin
              blink_cnt <= '0;
              alarm     <= ~alarm;
            end else begin
              blink_cnt <= blink_cnt + 8'd1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: loading, clamping, borrow, pause rules,
// expiry, alarm blink and asynchronous reset.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        start_stop = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [7:0]  sw_digits = 8'h00;
  logic [23:0] digits;
  logic        running;
  logic        expired;
  logic        alarm;

  int n_assert = 0;
  int n_fail   = 0;

  countdown_timer #(.BLINK_TICKS(50)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .load       (load),
    .sel        (sel),
    .sw_digits  (sw_digits),
    .digits     (digits),
    .running    (running),
    .expired    (expired),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] s, input logic [7:0] v);
    load = 1'b1; sel = s; sw_digits = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_ss();
    start_stop = 1'b1;
    @(posedge clk); #1;
    start_stop = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_digits", digits, 24'h0);
    chk("rst_running", 24'(running), 24'h0);
    chk("rst_expired", 24'(expired), 24'h0);
    chk("rst_alarm", 24'(alarm), 24'h0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Clamping in IDLE
    do_load(2'b10, 8'h7B);
    chk("clamp_sec", digits, 24'h005900);
    do_load(2'b01, 8'hFF);
    chk("clamp_hun", digits, 24'h005999);
    do_load(2'b11, 8'hA7);
    chk("clamp_min", digits, 24'h575999);
    do_load(2'b00, 8'h37);
    chk("clear_all", digits, 24'h0);

    // Zero start stays IDLE
    do_ss();
    chk("zero_start_running", 24'(running), 24'h0);

    // Borrow chain
    do_load(2'b11, 8'h01);
    chk("load_min", digits, 24'h010000);
    do_ss();
    chk("start_running", 24'(running), 24'h1);
    do_ticks(1);
    chk("borrow_chain", digits, 24'h005999);

    // Pause, clear to zero, resume: first tick expires without decrement
    do_ss();
    chk("pause_running", 24'(running), 24'h0);
    do_load(2'b00, 8'h00);
    chk("pause_clear", digits, 24'h0);
    do_ss();
    chk("resume_zero_running", 24'(running), 24'h1);
    do_ticks(1);
    chk("zero_tick_digits", digits, 24'h0);
    chk("zero_tick_expired", 24'(expired), 24'h1);
    chk("zero_tick_running", 24'(running), 24'h0);
    do_ss();
    chk("done_exit_expired", 24'(expired), 24'h0);

    // Pause wins over a coincident tick; load in RUN ignored
    do_load(2'b10, 8'h10);
    do_ss();
    start_stop = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    start_stop = 1'b0; tick = 1'b0;
    chk("ss_tick_running", 24'(running), 24'h0);
    chk("ss_tick_digits", digits, 24'h001000);
    do_ss();
    do_load(2'b11, 8'h05);
    chk("run_load_ignored", digits, 24'h001000);
    chk("run_load_running", 24'(running), 24'h1);
    do_ticks(1);
    chk("run_tick", digits, 24'h000999);
    do_ss();
    do_ticks(3);
    chk("pause_tick_ignored", digits, 24'h000999);

    // Load beats start_stop in the same cycle (PAUSE)
    start_stop = 1'b1; load = 1'b1; sel = 2'b01; sw_digits = 8'h42;
    @(posedge clk); #1;
    start_stop = 1'b0; load = 1'b0;
    chk("load_ss_digits", digits, 24'h000942);
    chk("load_ss_running", 24'(running), 24'h0);

    // Full minute countdown
    do_load(2'b00, 8'h00);
    do_ss();
    chk("paused_zero_resume", 24'(running), 24'h1);
    do_ticks(1);
    do_ss();
    chk("to_idle_expired", 24'(expired), 24'h0);
    do_load(2'b11, 8'h01);
    do_ss();
    do_ticks(1);
    chk("full_tick1", digits, 24'h005999);
    do_ticks(99);
    chk("full_tick100", digits, 24'h005900);
    do_ticks(5899);
    chk("full_tick5999", digits, 24'h000001);
    chk("full_tick5999_exp", 24'(expired), 24'h0);
    do_ticks(1);
    chk("full_tick6000", digits, 24'h0);
    chk("full_expired", 24'(expired), 24'h1);
    chk("full_running", 24'(running), 24'h0);
    chk("full_alarm", 24'(alarm), 24'h1);

    // Alarm blink
    do_ticks(49);
    chk("blink_49", 24'(alarm), 24'h1);
    do_ticks(1);
    chk("blink_50", 24'(alarm), 24'h0);
    do_ticks(49);
    chk("blink_99", 24'(alarm), 24'h0);
    do_ticks(1);
    chk("blink_100", 24'(alarm), 24'h1);
    chk("done_digits", digits, 24'h0);
    do_ss();
    chk("exit_expired", 24'(expired), 24'h0);
    chk("exit_alarm", 24'(alarm), 24'h0);
    chk("exit_digits", digits, 24'h0);

    // Asynchronous reset mid-RUN
    do_load(2'b10, 8'h30);
    do_load(2'b01, 8'h45);
    do_ss();
    chk("pre_reset_digits", digits, 24'h003045);
    #2 reset = 1'b0;
    #1;
    chk("async_digits", digits, 24'h0);
    chk("async_running", 24'(running), 24'h0);
    #2 reset = 1'b1;
    do_ticks(1);
    chk("post_reset_tick", digits, 24'h0);
    chk("post_reset_running", 24'(running), 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
